// File: rtl/a2con_pkg.sv
// a2con_pkg: shared constants for the Apple II console FIFO bridge.
// Holds the Apple slot register offsets, STATUS bit positions, STATUS
// write-clear bit positions, the default FIFO depth and a helper that packs
// the STATUS byte.
package a2con_pkg;

  localparam int A2C_DEPTH_DEF = 16;

  // Apple slot register offsets
  localparam logic [3:0] A2C_STATUS = 4'd0;
  localparam logic [3:0] A2C_RXPUSH = 4'd1;
  localparam logic [3:0] A2C_TXCNT  = 4'd2;
  localparam logic [3:0] A2C_TXPOP  = 4'd3;
  localparam logic [3:0] A2C_RXFREE = 4'd4;

  // STATUS read bit positions
  localparam int ST_TX_NEMPTY = 7;
  localparam int ST_RX_FULL   = 6;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_RX_OVF    = 4;

  // STATUS write: 1 in these bits clears the matching overflow flag
  localparam int CLR_RX_OVF = 0;
  localparam int CLR_TX_OVF = 1;

  function automatic logic [7:0] a2c_status(input logic tx_nempty, input logic rx_full,
                                            input logic tx_ovf, input logic rx_ovf);
    logic [7:0] v;
    v = 8'h00;
    v[ST_TX_NEMPTY] = tx_nempty;
    v[ST_RX_FULL]   = rx_full;
    v[ST_TX_OVF]    = tx_ovf;
    v[ST_RX_OVF]    = rx_ovf;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (pointers/count only)
//   flush     synchronous flush, same effect as rst on pointers/count
//   push/din  write request and data
//   pop       read request; dout always shows the current head
//   count     occupancy 0..DEPTH
//   full/empty occupancy flags
//   ovf_pulse push dropped because full with no concurrent pop
// Storage is not reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf_pulse
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Occupancy flags and the push/pop qualification.
  always_comb begin
    empty     = (r_count == {CW{1'b0}});
    full      = (r_count == CW'(DEPTH));
    // a pop on empty is ignored; a push on full only lands if a pop frees a slot
    w_do_pop  = pop & ~empty;
    w_do_push = push & (~full | w_do_pop);
    ovf_pulse = push & full & ~pop & ~flush;
    dout      = r_mem[r_rd_ptr];
    count     = r_count;
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write port; a push coinciding with a flush is discarded.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/a2_console_fifo.sv
// a2_console_fifo: buffered console bridge between the DCJ11 DLART register
// decode and the Apple II slot registers.
//   TX FIFO: filled by cpu_xwr (XBUF writes), drained by Apple offset-3 reads.
//   RX FIFO: filled by Apple offset-1 writes, drained by cpu_rrd (RBUF reads).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_init            RESET-instruction pulse: flush both FIFOs and flags
//   cpu_xwr/cpu_xdata   XBUF write strobe and byte
//   cpu_rrd             RBUF consume strobe
//   cpu_rdata           RX head, or last popped byte when RX is empty
//   cpu_rdone/cpu_xdone RX non-empty / TX not full
//   a2_sel/a2_rw/a2_addr/a2_wdata  Apple DEVSEL level, direction, offset, data
//   a2_rdata            registered Apple read data
module a2_console_fifo
  import a2con_pkg::*;
#(
  parameter int DEPTH = A2C_DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_init,
  input  logic       cpu_xwr,
  input  logic [7:0] cpu_xdata,
  input  logic       cpu_rrd,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rdone,
  output logic       cpu_xdone,
  input  logic       a2_sel,
  input  logic       a2_rw,
  input  logic [3:0] a2_addr,
  input  logic [7:0] a2_wdata,
  output logic [7:0] a2_rdata
);

  logic          r_a2_sel_q;
  logic [7:0]    r_a2_rdata;
  logic [7:0]    r_last_rbuf;
  logic          r_tx_ovf;
  logic          r_rx_ovf;

  logic          w_acc, w_rd_acc, w_wr_acc;
  logic          w_tx_pop, w_rx_push, w_rx_pop, w_clr;
  logic [7:0]    w_rd_val;
  logic [7:0]    w_tx_dout, w_rx_dout;
  logic [CW-1:0] w_tx_count, w_rx_count, w_rx_free;
  logic          w_tx_full, w_tx_empty, w_tx_ovf_p;
  logic          w_rx_full, w_rx_empty, w_rx_ovf_p;

  // Apple access strobe: one access per DEVSEL rising edge, decoded by offset.
  always_comb begin
    w_acc     = a2_sel & ~r_a2_sel_q;
    w_rd_acc  = w_acc & a2_rw;
    w_wr_acc  = w_acc & ~a2_rw;
    w_tx_pop  = w_rd_acc & (a2_addr == A2C_TXPOP);
    w_rx_push = w_wr_acc & (a2_addr == A2C_RXPUSH);
    w_clr     = w_wr_acc & (a2_addr == A2C_STATUS);
    w_rx_pop  = cpu_rrd & ~w_rx_empty;
    w_rx_free = CW'(DEPTH) - w_rx_count;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(cpu_init),
    .push(cpu_xwr), .pop(w_tx_pop), .din(cpu_xdata), .dout(w_tx_dout),
    .count(w_tx_count), .full(w_tx_full), .empty(w_tx_empty), .ovf_pulse(w_tx_ovf_p)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(cpu_init),
    .push(w_rx_push), .pop(cpu_rrd), .din(a2_wdata), .dout(w_rx_dout),
    .count(w_rx_count), .full(w_rx_full), .empty(w_rx_empty), .ovf_pulse(w_rx_ovf_p)
  );

  // Apple read mux, evaluated on pre-update state so a concurrent flush
  // still returns what the Apple would have seen.
  always_comb begin
    w_rd_val = 8'h00;
    case (a2_addr)
      A2C_STATUS: w_rd_val = a2c_status(~w_tx_empty, w_rx_full, r_tx_ovf, r_rx_ovf);
      A2C_TXCNT:  w_rd_val = 8'(w_tx_count);
      A2C_TXPOP:  w_rd_val = w_tx_empty ? 8'h00 : w_tx_dout;
      A2C_RXFREE: w_rd_val = 8'(w_rx_free);
      default:    w_rd_val = 8'h00;
    endcase
  end

  // Edge-detect, Apple read register, last popped RBUF byte, overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a2_sel_q  <= 1'b0;
      r_a2_rdata  <= 8'h00;
      r_last_rbuf <= 8'h00;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
    end else begin
      r_a2_sel_q <= a2_sel;
      if (w_rd_acc) r_a2_rdata <= w_rd_val;
      if (w_rx_pop) r_last_rbuf <= w_rx_dout;
      if (cpu_init) begin
        r_tx_ovf <= 1'b0;
        r_rx_ovf <= 1'b0;
      end else begin
        // a new overflow beats a same-cycle clear so the event is not lost
        if (w_tx_ovf_p)                         r_tx_ovf <= 1'b1;
        else if (w_clr && a2_wdata[CLR_TX_OVF]) r_tx_ovf <= 1'b0;
        if (w_rx_ovf_p)                         r_rx_ovf <= 1'b1;
        else if (w_clr && a2_wdata[CLR_RX_OVF]) r_rx_ovf <= 1'b0;
      end
    end
  end

  // CPU-side status is combinational from registered counts.
  always_comb begin
    cpu_rdata = w_rx_empty ? r_last_rbuf : w_rx_dout;
    cpu_rdone = ~w_rx_empty;
    cpu_xdone = ~w_tx_full;
    a2_rdata  = r_a2_rdata;
  end

endmodule

// File: tb/tb_a2_console_fifo.sv
// Scoreboard bench for a2_console_fifo: a queue-based reference model
// predicts outputs for every cycle; a negedge monitor pops and compares.
module tb_a2_console_fifo;

  localparam int DEPTH = 16;
  localparam int K_A2 = 0, K_RDATA = 1, K_RDONE = 2, K_XDONE = 3;

  logic       clk = 1'b0;
  logic       rst, cpu_init, cpu_xwr, cpu_rrd, a2_sel, a2_rw;
  logic [7:0] cpu_xdata, a2_wdata;
  logic [3:0] a2_addr;
  logic [7:0] cpu_rdata, a2_rdata;
  logic       cpu_rdone, cpu_xdone;

  always #5 clk = ~clk;

  a2_console_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_init(cpu_init), .cpu_xwr(cpu_xwr), .cpu_xdata(cpu_xdata),
    .cpu_rrd(cpu_rrd), .cpu_rdata(cpu_rdata), .cpu_rdone(cpu_rdone), .cpu_xdone(cpu_xdone),
    .a2_sel(a2_sel), .a2_rw(a2_rw), .a2_addr(a2_addr), .a2_wdata(a2_wdata), .a2_rdata(a2_rdata)
  );

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_txovf = 1'b0, m_rxovf = 1'b0, m_selq = 1'b0;
  logic [7:0] m_last = 8'h00, m_a2rd = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_A2:    return "a2_rdata";
      K_RDATA: return "cpu_rdata";
      K_RDONE: return "cpu_rdone";
      default: return "cpu_xdone";
    endcase
  endfunction

  // monitor: compare every expectation that has come due
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_A2:    act = a2_rdata;
        K_RDATA: act = cpu_rdata;
        K_RDONE: act = {7'b0, cpu_rdone};
        default: act = {7'b0, cpu_xdone};
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d actual=%02h required=%02h", kname(e.kind), cyc, act, e.val);
      end
    end
  end

  task automatic expect_now(input int kind, input logic [7:0] val);
    exp_t e;
    e.due = cyc; e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // queue the predicted post-edge outputs, then clock the DUT.
  task automatic step();
    logic       acc;
    int         ts, rs;
    exp_t       e;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      m_txovf = 1'b0; m_rxovf = 1'b0; m_last = 8'h00; m_a2rd = 8'h00; m_selq = 1'b0;
    end else begin
      acc = a2_sel && !m_selq;
      ts  = tx_q.size();
      rs  = rx_q.size();
      if (acc && a2_rw) begin
        case (a2_addr)
          4'd0:    m_a2rd = {ts != 0, rs == DEPTH, m_txovf, m_rxovf, 4'b0000};
          4'd2:    m_a2rd = 8'(ts);
          4'd3:    m_a2rd = (ts != 0) ? tx_q[0] : 8'h00;
          4'd4:    m_a2rd = 8'(DEPTH - rs);
          default: m_a2rd = 8'h00;
        endcase
      end
      if (cpu_init) begin
        if (cpu_rrd && rs != 0) m_last = rx_q[0];
        tx_q.delete(); rx_q.delete();
        m_txovf = 1'b0; m_rxovf = 1'b0;
      end else begin
        if (acc && !a2_rw && a2_addr == 4'd0) begin
          if (a2_wdata[0]) m_rxovf = 1'b0;
          if (a2_wdata[1]) m_txovf = 1'b0;
        end
        if (acc && a2_rw && a2_addr == 4'd3 && ts != 0) void'(tx_q.pop_front());
        if (cpu_xwr) begin
          if (tx_q.size() < DEPTH) tx_q.push_back(cpu_xdata);
          else m_txovf = 1'b1;
        end
        if (cpu_rrd && rs != 0) m_last = rx_q.pop_front();
        if (acc && !a2_rw && a2_addr == 4'd1) begin
          if (rx_q.size() < DEPTH) rx_q.push_back(a2_wdata);
          else m_rxovf = 1'b1;
        end
      end
      m_selq = a2_sel;
    end
    e.due = cyc + 1;
    e.kind = K_A2;    e.val = m_a2rd;                                        exp_q.push_back(e);
    e.kind = K_RDATA; e.val = (rx_q.size() != 0) ? rx_q[0] : m_last;         exp_q.push_back(e);
    e.kind = K_RDONE; e.val = {7'b0, rx_q.size() != 0};                      exp_q.push_back(e);
    e.kind = K_XDONE; e.val = {7'b0, tx_q.size() < DEPTH};                   exp_q.push_back(e);
    @(posedge clk);
    #1;
    cpu_init = 1'b0; cpu_xwr = 1'b0; cpu_rrd = 1'b0;
  endtask

  task automatic xwr(input logic [7:0] d);
    cpu_xwr = 1'b1; cpu_xdata = d; step();
  endtask

  // Apple read: DEVSEL high for one cycle, check the directed value, release.
  task automatic a2_rd(input logic [3:0] addr, input logic [7:0] expv);
    a2_sel = 1'b1; a2_rw = 1'b1; a2_addr = addr; step();
    expect_now(K_A2, expv);
    a2_sel = 1'b0; step();
  endtask

  task automatic a2_wr(input logic [3:0] addr, input logic [7:0] d);
    a2_sel = 1'b1; a2_rw = 1'b0; a2_addr = addr; a2_wdata = d; step();
    a2_sel = 1'b0; step();
  endtask

  initial begin
    int p_xwr, p_rrd;
    rst = 1'b1; cpu_init = 1'b0; cpu_xwr = 1'b0; cpu_rrd = 1'b0;
    a2_sel = 1'b0; a2_rw = 1'b0; a2_addr = 4'd0; a2_wdata = 8'h00; cpu_xdata = 8'h00;
    step(); step();
    expect_now(K_XDONE, 8'h01); expect_now(K_RDONE, 8'h00);
    expect_now(K_RDATA, 8'h00); expect_now(K_A2, 8'h00);
    rst = 1'b0; step();

    // TX basic path
    xwr(8'h41); xwr(8'h42); xwr(8'h43);
    a2_rd(4'd2, 8'h03);
    a2_rd(4'd3, 8'h41); a2_rd(4'd3, 8'h42); a2_rd(4'd3, 8'h43);
    a2_rd(4'd3, 8'h00);
    a2_rd(4'd0, 8'h00);

    // TX overflow and flag clear
    for (int i = 0; i < 16; i++) xwr(8'(8'h50 + i));
    expect_now(K_XDONE, 8'h00);
    xwr(8'hEE);
    a2_rd(4'd0, 8'hA0);
    a2_wr(4'd0, 8'h02);
    a2_rd(4'd0, 8'h80);
    for (int i = 0; i < 16; i++) a2_rd(4'd3, 8'(8'h50 + i));

    // RX path and last_rbuf hold
    a2_wr(4'd1, 8'h0D); a2_wr(4'd1, 8'h0A);
    expect_now(K_RDONE, 8'h01); expect_now(K_RDATA, 8'h0D);
    cpu_rrd = 1'b1; step();
    expect_now(K_RDATA, 8'h0A); expect_now(K_RDONE, 8'h01);
    cpu_rrd = 1'b1; step();
    expect_now(K_RDONE, 8'h00); expect_now(K_RDATA, 8'h0A);

    // RX full with simultaneous push and pop
    for (int i = 0; i < 16; i++) a2_wr(4'd1, 8'(8'h60 + i));
    a2_rd(4'd4, 8'h00);
    cpu_rrd = 1'b1;
    a2_wr(4'd1, 8'h77);
    a2_rd(4'd0, 8'h40);
    a2_rd(4'd4, 8'h00);

    // cpu_init concurrent with an Apple count read
    for (int i = 0; i < 5; i++) xwr(8'(8'h30 + i));
    cpu_init = 1'b1;
    a2_rd(4'd2, 8'h05);
    expect_now(K_XDONE, 8'h01); expect_now(K_RDONE, 8'h00);
    a2_rd(4'd0, 8'h00);
    a2_rd(4'd2, 8'h00);

    // held DEVSEL pops exactly once
    xwr(8'hAA); xwr(8'hBB);
    a2_sel = 1'b1; a2_rw = 1'b1; a2_addr = 4'd3;
    for (int i = 0; i < 10; i++) step();
    expect_now(K_A2, 8'hAA);
    a2_sel = 1'b0; step();
    a2_rd(4'd2, 8'h01);

    // randomized phases with varying producer/consumer bias
    for (int ph = 0; ph < 6; ph++) begin
      p_xwr = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      p_rrd = (ph % 2 == 0) ? 15 : 70;
      for (int i = 0; i < 400; i++) begin
        rst      = ($urandom_range(0, 399) == 0);
        cpu_init = ($urandom_range(0, 99) == 0);
        cpu_xwr  = ($urandom_range(0, 99) < p_xwr);
        cpu_rrd  = !cpu_init && ($urandom_range(0, 99) < p_rrd);
        cpu_xdata = 8'($urandom);
        a2_sel   = ($urandom_range(0, 2) != 0) ? ~a2_sel : a2_sel;
        a2_rw    = 1'($urandom);
        a2_addr  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
        a2_wdata = 8'($urandom);
        step();
      end
    end

    rst = 1'b0; a2_sel = 1'b0;
    step(); step();
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a2_console_fifo.md
# a2_console_fifo

Buffered console bridge between the DCJ11 DLART register decode and the Apple II slot registers. It replaces the single-byte XBUF/RBUF strobe handshake with two FIFOs:
- a TX FIFO (PDP-11 → Apple) filled by XBUF writes and drained by Apple reads;
- an RX FIFO (Apple → PDP-11) filled by Apple writes and drained by RBUF reads.

It sits directly downstream of the DCJ11 bus-cycle/register decode and upstream of the Apple II data-bus driver, all in the `clk` domain.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH)+1`: occupancy counter width.

Ports:
- `clk`  in  1  fabric clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cpu_init`  in  1  one-cycle pulse on RESET instruction (GP code 014); flushes both FIFOs and clears flags.
- `cpu_xwr`  in  1  one-cycle pulse: DCJ11 wrote XBUF.
- `cpu_xdata`  in  8  XBUF write byte, valid with `cpu_xwr`.
- `cpu_rrd`  in  1  one-cycle pulse: DCJ11 read RBUF (consume).
- `cpu_rdata`  out  8  RBUF read value.
- `cpu_rdone`  out  1  RCSR bit 7: RX FIFO non-empty.
- `cpu_xdone`  out  1  XCSR bit 7: TX FIFO not full.
- `a2_sel`  in  1  synchronized, active-high DEVSEL level.
- `a2_rw`  in  1  1 = Apple read, 0 = Apple write; sampled at the `a2_sel` rising edge.
- `a2_addr`  in  4  slot register offset.
- `a2_wdata`  in  8  Apple write data.
- `a2_rdata`  out  8  Apple read data, registered.

## Operation

Apple register map (offsets 5–15: reads return 0x00, writes are ignored):
- 0 R: STATUS = {tx_nempty, rx_full, tx_ovf, rx_ovf, 4'b0}.
- 0 W: bit 0 = 1 clears `rx_ovf`; bit 1 = 1 clears `tx_ovf`.
- 1 W: push `a2_wdata` into the RX FIFO.
- 2 R: {0, tx_count}.
- 3 R: TX head byte, with pop.
- 4 R: {0, DEPTH − rx_count}.

Apple access rules:
- One access per `a2_sel` assertion. It is acted on only in the cycle after the rising edge (edge-detect register `a2_sel_q`).
- A held `a2_sel` never repeats an access.

TX FIFO:
- `cpu_xwr` pushes `cpu_xdata`.
- A push while full with no concurrent pop is dropped and sets `tx_ovf`.
- An Apple read of offset 3 while empty returns 0x00 and does not pop.

RX FIFO:
- An Apple write to offset 1 pushes `a2_wdata`.
- A push while full with no concurrent pop is dropped and sets `rx_ovf`.
- `cpu_rrd` while empty is a no-op.

`cpu_rdata`:
- Equals the RX head when non-empty, otherwise `last_rbuf`.
- `last_rbuf` loads the popped byte on every RX pop.

Simultaneous events:
- Push and pop on the same FIFO in the same cycle:
  - when non-empty, both take effect and the count is unchanged;
  - when empty, the pop is ignored and the push succeeds;
  - when full, the pop is honoured and the push is accepted.
- `cpu_init` together with any push, pop or Apple access:
  - the flush wins and pointers, counts and both overflow flags go to 0;
  - a concurrent Apple read still returns the value computed from the pre-flush state;
  - a concurrent push is discarded without setting overflow.

Pointer and count arithmetic:
- Pointers are `$clog2(DEPTH)` bits and wrap naturally modulo DEPTH.
- Counts saturate in range `0..DEPTH` by construction and never wrap.

## Timing

Reset values:
- `cpu_rdata` = 0x00, `cpu_rdone` = 0, `cpu_xdone` = 1, `a2_rdata` = 0x00.
- Flags 0, counts 0, `a2_sel_q` = 0.

Latency:
- `cpu_xwr` at cycle N: `tx_count` and status update at N+1. `cpu_xdone` falls at N+1 if the FIFO became full.
- `cpu_rrd` at N: `cpu_rdata` shows the next head or `last_rbuf` at N+1, and `cpu_rdone` updates at N+1.
- `a2_sel` rises at N with `a2_sel_q` = 0:
  - at N+1, `a2_rdata` loads and any push or pop commits;
  - counts are visible at N+2.
- `a2_rdata` holds until the next Apple read access.
- `cpu_rdone` and `cpu_xdone` are combinational from registered counts, with no pulse stretching.
- Reset asserted mid-operation has the same effect as `cpu_init` on the next edge, and in addition clears `a2_rdata`, `last_rbuf` and `a2_sel_q`.
- FIFO storage is not reset.

## Structure
- Package `a2con_pkg` holds:
  - register offsets `A2C_STATUS`, `A2C_RXPUSH`, `A2C_TXCNT`, `A2C_TXPOP`, `A2C_RXFREE`;
  - status bit indices;
  - default `DEPTH`.
- Sub-module `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`; signals `push`, `pop`, `flush`, `din`, `dout` (first-word fall-through head), `count`, `full`, `empty`, `ovf_pulse`;
  - instantiated twice (TX and RX).
- The top level contains the Apple edge detect, register decode, read mux, overflow flags and `last_rbuf`.

## Test plan
- Reset, then 3 `cpu_xwr` pulses of 0x41, 0x42, 0x43 → Apple offset 2 reads 0x03; three offset-3 reads return 0x41, 0x42, 0x43; a fourth offset-3 read returns 0x00; STATUS bit 7 = 0.
- 17 `cpu_xwr` pulses with DEPTH = 16 → `cpu_xdone` = 0 after the 16th; STATUS reads 0xA0 (`tx_nempty` + `tx_ovf`); an Apple write of 0x02 to offset 0 clears bit 5.
- Apple writes 0x0D then 0x0A to offset 1 → `cpu_rdone` = 1 and `cpu_rdata` = 0x0D; `cpu_rrd` gives 0x0A at N+1; a second `cpu_rrd` leaves `cpu_rdone` = 0 with `cpu_rdata` held at 0x0A.
- RX full (16 entries), then an Apple offset-1 write in the same cycle as `cpu_rrd` → count stays 16 and `rx_ovf` stays 0; an offset-4 read returns 0x00.
- `cpu_init` while TX holds 5 entries and `a2_sel` rises the same cycle on offset 2 → the read returns 0x05; next cycle the counts are 0, `cpu_xdone` = 1 and the flags are 0.
- `a2_sel` held high for 10 cycles on offset 3 with 2 TX entries → exactly one pop; `tx_count` = 1.
